spi_tx_fifo: RTL and testbench

SPI_TX_FIFO -- requirements
Module: spi_tx_fifo

---
 rtl/spi_fifo_pkg.sv | 5 +
 rtl/spi_fifo_ram.sv | 19 +
 rtl/spi_tx_fifo.sv | 89 ++++++++
 tb/tb_spi_tx_fifo.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/spi_fifo_pkg.sv
// spi_fifo_pkg: word width and default depth shared by the SPI stage and its tx FIFO
package spi_fifo_pkg;
  localparam int SPI_WORD_W = 15;
  localparam int SPI_FIFO_DEPTH_DEF = 512;
endpackage

// File: rtl/spi_fifo_ram.sv
// spi_fifo_ram: simple dual-port block RAM with registered read
module spi_fifo_ram #(
  parameter int DATA_W = 15,
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wa,
  input  logic [DATA_W-1:0]        wd,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] ra,
  output logic [DATA_W-1:0]        rd
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) rd <= mem[ra];
  end
endmodule

// File: rtl/spi_tx_fifo.sv
// spi_tx_fifo: FWFT tx FIFO (head reg + bypass stage + RAM); define SPI_TX_FIFO_OVF_CNT_EN to build ovf_cnt
module spi_tx_fifo import spi_fifo_pkg::*; #(
  parameter int DATA_W = SPI_WORD_W,
  parameter int DEPTH = SPI_FIFO_DEPTH_DEF,
  parameter int AFULL_TH = DEPTH - 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     clr,
  input  logic                     fifo_rd,
  output logic [DATA_W-1:0]        fifo_data,
  output logic                     fifo_empty,
  output logic                     full,
  output logic                     afull,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  output logic                     udf,
  output logic [15:0]              ovf_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_V = LW'(DEPTH);
  localparam logic [LW-1:0] AF_V = LW'(AFULL_TH < 0 ? 0 : AFULL_TH);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0] byp, ram_q, q_eff;
  logic dv, qv, sel;
  logic pop, we, drop, d_take, s_free, to_d, to_s, to_ram, ren;
  spi_fifo_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk(clk), .we(to_ram), .wa(wr_ptr), .wd(wr_data),
    .re(ren), .ra(rd_ptr), .rd(ram_q)
  );
  assign fifo_empty = !dv;
  assign full = level == FULL_V;
  assign afull = level >= AF_V;
  always_comb begin
    pop = fifo_rd & dv;
    we = wr_en & (!full | pop);
    drop = wr_en & full & !pop;
    d_take = !dv | pop;
    to_d = d_take & !qv & we;
    s_free = !qv | d_take;
    ren = s_free & (wr_ptr != rd_ptr);
    to_s = s_free & !ren & we & !to_d;
    to_ram = we & !to_d & !to_s;
    q_eff = sel ? byp : ram_q;
  end
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      dv <= 1'b0;
      qv <= 1'b0;
      sel <= 1'b0;
      byp <= '0;
      fifo_data <= '0;
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (d_take) begin
        dv <= qv | we;
        if (qv) fifo_data <= q_eff;
        else if (we) fifo_data <= wr_data;
      end
      if (s_free) begin
        qv <= ren | to_s;
        sel <= to_s;
      end
      if (to_s) byp <= wr_data;
      if (ren) rd_ptr <= rd_ptr + 1'b1;
      if (to_ram) wr_ptr <= wr_ptr + 1'b1;
      level <= level + LW'(we) - LW'(pop);
      ovf <= ovf | drop;
      udf <= udf | (fifo_rd & !dv);
    end
  end
`ifdef SPI_TX_FIFO_OVF_CNT_EN
  logic [15:0] cnt;
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (drop && cnt != 16'hFFFF) cnt <= cnt + 1'b1;
  end
  assign ovf_cnt = cnt;
`else
  assign ovf_cnt = '0;
`endif
endmodule

// File: tb/tb_spi_tx_fifo.sv
// tb_spi_tx_fifo: directed and queue-checked random tests for spi_tx_fifo
module tb_spi_tx_fifo;
  localparam int DEPTH = 512;
  localparam int AFT = DEPTH - 16;
`ifdef SPI_TX_FIFO_OVF_CNT_EN
  localparam int OVF_EXP = 1;
`else
  localparam int OVF_EXP = 0;
`endif
  logic clk = 0, rst = 0, wr_en = 0, clr = 0, fifo_rd = 0;
  logic [14:0] wr_data = '0;
  logic [14:0] fifo_data;
  logic fifo_empty, full, afull, ovf, udf;
  logic [9:0] level;
  logic [15:0] ovf_cnt;
  int checks = 0, errors = 0;
  logic [14:0] q[$];
  spi_tx_fifo dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .clr(clr),
    .fifo_rd(fifo_rd), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .full(full), .afull(afull), .level(level), .ovf(ovf), .udf(udf),
    .ovf_cnt(ovf_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_rst;
    rst = 1; wr_en = 0; fifo_rd = 0; clr = 0;
    tick;
    rst = 0;
  endtask
  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      wr_en = 1; wr_data = 15'(i);
      tick;
      if (i + 1 == AFT - 1) chk("afull_below", int'(afull), 0);
      if (i + 1 == AFT) chk("afull_at", int'(afull), 1);
    end
    wr_en = 0;
  endtask
  task automatic idle_flags(input string tag);
    chk({tag, "_level"}, int'(level), 0);
    chk({tag, "_empty"}, int'(fifo_empty), 1);
    chk({tag, "_full"}, int'(full), 0);
    chk({tag, "_afull"}, int'(afull), 0);
    chk({tag, "_ovf"}, int'(ovf), 0);
    chk({tag, "_udf"}, int'(udf), 0);
    chk({tag, "_ovfcnt"}, int'(ovf_cnt), 0);
  endtask
  initial begin
    tick;
    do_rst;
    idle_flags("rst");
    chk("rst_data", int'(fifo_data), 0);
    wr_en = 1; wr_data = 15'h1234;
    tick;
    wr_en = 0;
    chk("w1_empty", int'(fifo_empty), 0);
    chk("w1_data", int'(fifo_data), 'h1234);
    chk("w1_level", int'(level), 1);
    fifo_rd = 1;
    tick;
    fifo_rd = 0;
    chk("p1_empty", int'(fifo_empty), 1);
    chk("p1_level", int'(level), 0);
    do_rst;
    fill(DEPTH);
    chk("fill_full", int'(full), 1);
    chk("fill_level", int'(level), DEPTH);
    chk("fill_ovf", int'(ovf), 0);
    wr_en = 1; wr_data = 15'h7FFF;
    tick;
    wr_en = 0;
    chk("ovf_flag", int'(ovf), 1);
    chk("ovf_cnt", int'(ovf_cnt), OVF_EXP);
    chk("ovf_level", int'(level), DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_order", int'(fifo_data), i);
      fifo_rd = 1;
      tick;
    end
    fifo_rd = 0;
    chk("drain_empty", int'(fifo_empty), 1);
    chk("drain_level", int'(level), 0);
    chk("drain_ovf_sticky", int'(ovf), 1);
    clr = 1;
    tick;
    clr = 0;
    chk("clr_ovf", int'(ovf), 0);
    chk("clr_ovfcnt", int'(ovf_cnt), 0);
    do_rst;
    fill(DEPTH);
    wr_en = 1; fifo_rd = 1; wr_data = 15'h7FFF;
    tick;
    wr_en = 0; fifo_rd = 0;
    chk("fullrw_level", int'(level), DEPTH);
    chk("fullrw_full", int'(full), 1);
    chk("fullrw_ovf", int'(ovf), 0);
    for (int i = 1; i <= DEPTH; i++) begin
      chk("fullrw_order", int'(fifo_data), i < DEPTH ? i : 'h7FFF);
      fifo_rd = 1;
      tick;
    end
    fifo_rd = 0;
    chk("fullrw_empty", int'(fifo_empty), 1);
    do_rst;
    wr_en = 1; fifo_rd = 1; wr_data = 15'h0055;
    tick;
    wr_en = 0; fifo_rd = 0;
    chk("erw_udf", int'(udf), 1);
    chk("erw_data", int'(fifo_data), 'h0055);
    chk("erw_level", int'(level), 1);
    chk("erw_empty", int'(fifo_empty), 0);
    fill(2);
    chk("pre_clr_level", int'(level), 3);
    clr = 1; wr_en = 1; wr_data = 15'h0AAA;
    tick;
    clr = 0; wr_en = 0;
    idle_flags("clr");
    fifo_rd = 1;
    tick;
    fifo_rd = 0;
    chk("pre_rst_udf", int'(udf), 1);
    fill(3);
    chk("pre_rst_level", int'(level), 3);
    rst = 1; wr_en = 1; fifo_rd = 1; wr_data = 15'h0AAA;
    tick;
    rst = 0; wr_en = 0; fifo_rd = 0;
    idle_flags("mrst");
    chk("mrst_data", int'(fifo_data), 0);
    for (int c = 0; c < 3 * DEPTH; c++) begin
      int wp;
      logic w, r, p, a;
      wp = c < DEPTH ? 3 : (c < 2 * DEPTH ? 2 : 1);
      w = $urandom_range(0, 3) < wp;
      r = $urandom_range(0, 3) >= wp;
      wr_en = w; fifo_rd = r; wr_data = 15'($urandom);
      chk("rnd_empty", int'(fifo_empty), int'(q.size() == 0));
      if (q.size() > 0) chk("rnd_data", int'(fifo_data), int'(q[0]));
      p = r && q.size() > 0;
      a = w && (q.size() < DEPTH || p);
      if (p) void'(q.pop_front());
      if (a) q.push_back(wr_data);
      tick;
      chk("rnd_level", int'(level), q.size());
    end
    wr_en = 0; fifo_rd = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
